// File: rtl/register_write_arbiter_if.sv
// Write-request bus between datapath requesters and the register write arbiter.
// The requester side drives the In_* signals and the arbiter side drives the Out_* signals.
interface register_write_arbiter_if #(
  parameter int WIDTH      = 32,
  parameter int NUM_REQ    = 4,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [NUM_REQ-1:0]            In_Request;
  logic [NUM_REQ*ADDR_WIDTH-1:0] In_Addr;
  logic [NUM_REQ*WIDTH-1:0]      In_Data;
  logic [NUM_REQ-1:0]            Out_Grant;
  logic [NUM_REQ-1:0]            Out_Ack;
  logic [NUM_REGS-1:0]           Out_Write_Enable;
  logic [WIDTH-1:0]              Out_Write_Data;
  logic                          Out_Error;
  logic                          Out_Busy;

  modport master (
    output In_Request, In_Addr, In_Data,
    input  Out_Grant, Out_Ack, Out_Write_Enable, Out_Write_Data, Out_Error, Out_Busy
  );

  modport slave (
    input  In_Request, In_Addr, In_Data,
    output Out_Grant, Out_Ack, Out_Write_Enable, Out_Write_Data, Out_Error, Out_Busy
  );
endinterface

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter granting one register write per grant. Each grant is followed by a one-cycle
// WRITE state. All outputs are decoded from registered state only.
module register_write_arbiter #(
  parameter int WIDTH      = 32,
  parameter int NUM_REQ    = 4,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                    In_Clock,
  input  logic                    In_Reset,
  register_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      r_win;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_data;

  logic                  w_any;
  logic [PTR_W-1:0]      w_win;
  logic                  w_busy;
  logic                  w_addr_ok;

  // Descending scan, so the candidate closest to r_rr_ptr is the last one written and wins.
  always_comb begin
    int idx;
    // NOTE: every variable assigned in always_comb gets a default first; otherwise a path that skips it infers a latch.
    w_any = 1'b0;
    w_win = '0;
    idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (bus.In_Request[idx]) begin
        w_any = 1'b1;
        w_win = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next_state = S_WRITE;
      S_WRITE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge In_Clock or posedge In_Reset) begin
    if (In_Reset) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_win    <= '0;
      r_addr   <= '0;
      // NOTE: the latched data register is reset too, so Out_Write_Data reads 0 after reset.
      r_data   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && w_any) begin
        r_win  <= w_win;
        r_addr <= bus.In_Addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
        r_data <= bus.In_Data[w_win*WIDTH +: WIDTH];
      end
      if (r_state == S_WRITE) begin
        r_rr_ptr <= (r_win == PTR_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
      end
    end
  end

  assign w_busy    = (r_state == S_WRITE);
  assign w_addr_ok = (32'(r_addr) < 32'(NUM_REGS));

  always_comb begin
    bus.Out_Grant = '0;
    if (w_busy) bus.Out_Grant[r_win] = 1'b1;
  end

  // Out-of-range addresses still get an ack, but raise Out_Error instead of an enable.
  always_comb begin
    bus.Out_Write_Enable = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.Out_Write_Enable[i] = w_busy && w_addr_ok && (r_addr == ADDR_WIDTH'(i));
    end
  end

  assign bus.Out_Ack        = bus.Out_Grant;
  assign bus.Out_Write_Data = w_busy ? r_data : '0;
  assign bus.Out_Error      = w_busy && !w_addr_ok;
  assign bus.Out_Busy       = w_busy;
endmodule
